// File: rtl/pc_stack_gen_if.sv
// Decode-stage to PC-generator bus: op/operands in, PC and call-stack status out.
// SP_W is derived from STACK_DEPTH so both ends agree on the stack-level width.
interface pc_stack_gen_if #(
    parameter int ADDR_W      = 6,
    parameter int STACK_DEPTH = 4
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic              en;
    logic [2:0]        op;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] pc;
    logic [SP_W-1:0]   sp_level;
    logic              stack_full;
    logic              stack_empty;
    logic              err_ovf;
    logic              err_unf;

    modport master (
        output en, op, target, offset,
        input  pc, sp_level, stack_full, stack_empty, err_ovf, err_unf
    );

    modport slave (
        input  en, op, target, offset,
        output pc, sp_level, stack_full, stack_empty, err_ovf, err_unf
    );
endinterface

// File: rtl/pc_stack_gen.sv
// Program-counter generator with increment, jump, signed branch and a LIFO
// call/return stack carrying sticky overflow/underflow flags.
module pc_stack_gen #(
    parameter int ADDR_W      = 6,
    parameter int STACK_DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    pc_stack_gen_if.slave bus
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_INC  = 3'b001,
        OP_JMP  = 3'b010,
        OP_BRA  = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101
    } op_e;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              push;
    logic              full, empty;
    logic [IDX_W-1:0]  push_idx, top_idx;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

    assign full     = (sp_q == SP_W'(STACK_DEPTH));
    assign empty    = (sp_q == '0);
    assign push_idx = IDX_W'(sp_q);
    assign top_idx  = IDX_W'(sp_q - SP_W'(1));

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (bus.en) begin
            case (bus.op)
                OP_INC:  pc_d = pc_q + ADDR_W'(1);
                OP_JMP:  pc_d = bus.target;
                OP_BRA:  pc_d = pc_q + bus.offset;  // two's-complement add wraps both ways
                OP_CALL: begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SP_W'(1);
                        pc_d = bus.target;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        pc_d = stack_mem[top_idx];
                        sp_d = sp_q - SP_W'(1);
                    end
                end
                default: ;  // HOLD and reserved codes
            endcase
        end
    end

    // NOTE: clocked state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q  <= '0;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // NOTE: the stack array is deliberately not reset; sp_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            stack_mem[push_idx] <= pc_q + ADDR_W'(1);
        end
    end

    assign bus.pc          = pc_q;
    assign bus.sp_level    = sp_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.err_ovf     = ovf_q;
    assign bus.err_unf     = unf_q;
endmodule
